muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand, HI and LO width; legal values 8..64, even.
REQ-002 SHALL have parameter MUL_LAT, default 2: multiply latency in cycles; legal values 1..4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  operation request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_op  input  3  opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved.
REQ-008 SHALL have port req_src1  input  XLEN  rs value: multiplicand, dividend, or MTHI/MTLO data.
REQ-009 SHALL have port req_src2  input  XLEN  rt value: multiplier or divisor.
REQ-010 SHALL have port cancel  input  1  flush; aborts the in-flight operation.
REQ-011 SHALL have port busy  output  1  an operation is in flight.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port div_by_zero  output  1  high together with done when a DIV/DIVU divisor was 0.
REQ-014 SHALL have port hi  output  XLEN  HI register value.
REQ-015 SHALL have port lo  output  XLEN  LO register value.

Function
REQ-016 SHALL implement states IDLE, MUL, DIV and FIX; req_ready = (state==IDLE) && !cancel.
REQ-017 SHALL accept a request in a cycle where req_valid && req_ready, capturing op and operands at that edge.
REQ-018 SHALL, for MTHI/MTLO, write req_src1 into hi/lo at the accept edge, stay in IDLE and pulse done in the following cycle.
REQ-019 SHALL, for reserved opcodes, consume the request with no state change, no done and no hi/lo change.
REQ-020 SHALL, for MULT (signed) and MULTU (unsigned), form the 2*XLEN-bit product; hi = upper half, lo = lower half.
REQ-021 SHALL hold MUL for MUL_LAT cycles; hi/lo update and done asserts in the MUL_LAT-th cycle after the accept cycle.
REQ-022 SHALL, for DIV/DIVU, run a restoring divider at one quotient bit per cycle for XLEN cycles in DIV, then one FIX cycle for sign correction.
REQ-023 SHALL have done assert, with hi/lo updated in that same cycle, XLEN+2 cycles after the accept cycle; the latency is data-independent.
REQ-024 SHALL produce lo = quotient and hi = remainder; signed quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-025 SHALL, when the divisor is 0, produce lo = all ones and hi = dividend, with div_by_zero = 1 in the done cycle.
REQ-026 SHALL, for signed DIV of minimum-negative / -1, produce lo = minimum-negative and hi = 0, with no error flag.
REQ-027 SHALL hold busy = 1 exactly while state is MUL, DIV or FIX.
REQ-028 SHALL hold done and div_by_zero low in every cycle other than the completion cycle.
REQ-029 SHALL, when cancel is high in any cycle: next state IDLE, no done for the aborted operation, hi/lo unchanged.
REQ-030 SHALL give cancel priority over acceptance; a request presented while cancel is high is not accepted.
REQ-031 SHALL allow a new request to be accepted in the cycle immediately after done (back-to-back).
REQ-032 SHALL have hi/lo change only at MTHI/MTLO accept, MUL completion or FIX completion.

Reset
REQ-033 SHALL, while resetn is low, immediately force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0 and lo=0, regardless of the clock.
REQ-034 SHALL abandon any in-flight operation on reset, with no done after reset release.
REQ-035 SHALL have req_ready = 1 in the first cycle after resetn deasserts (cancel low).

Verification (XLEN=32, MUL_LAT=2)
REQ-036 SHALL cover: MULT 0xFFFFFFFF x 0x00000002 -> done 2 cycles after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFE; same operands with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 SHALL cover: DIVU 100/7 -> done 34 cycles after accept, lo=14, hi=2, busy high for 33 cycles; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 SHALL cover: DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-039 SHALL cover: DIV accepted, cancel pulsed on cycle 10 -> no done, hi/lo keep prior values, req_ready=1 next cycle, new MTLO 0x1234 accepted -> lo=0x1234.
REQ-040 SHALL cover: resetn dropped mid-DIV between clock edges -> outputs zero immediately, no done after release; plus MTHI 0xA5A5A5A5 immediately following a MULT done -> accepted, hi=0xA5A5A5A5.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit.
//   MULT/MULTU form a 2*XLEN-bit product in MUL_LAT cycles.
//   DIV/DIVU run a restoring divider at one quotient bit per cycle,
//   followed by one sign-fix cycle.
//   MTHI/MTLO write HI/LO directly.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_op selects the operation
//   req_src1, req_src2   rs / rt operands
//   cancel               abort the in-flight operation (beats acceptance)
//   busy                 MUL, DIV or FIX in progress
//   done, div_by_zero    one-cycle completion pulse and zero-divisor flag
//   hi, lo               architectural HI/LO registers
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW           = $clog2(XLEN + 1);
  localparam int MUL_FIRE_CNT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_t;

  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b;
  logic [XLEN-1:0]   r_rem, r_quo, r_dvs;
  logic              r_neg_q, r_neg_r;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_hi, r_lo;
  logic              r_done, r_dz;

  logic              w_accept, w_req_mul, w_req_div, w_req_sdiv;
  logic              w_mul_signed, w_mul_fire, w_q_bit;
  logic [XLEN-1:0]   w_ma, w_mb, w_abs_a, w_abs_b, w_fix_q, w_fix_r;
  logic [2*XLEN-1:0] w_ext_a, w_ext_b, w_prod;
  logic [XLEN:0]     w_shift, w_diff;

  assign req_ready   = (r_state == IDLE) && !cancel;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dz;
  assign hi          = r_hi;
  assign lo          = r_lo;

  assign w_accept   = req_valid && req_ready;
  assign w_req_mul  = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign w_req_div  = (req_op == OP_DIV)  || (req_op == OP_DIVU);
  assign w_req_sdiv = (req_op == OP_DIV);
  assign w_abs_a    = (w_req_sdiv && req_src1[XLEN-1]) ? -req_src1 : req_src1;
  assign w_abs_b    = (w_req_sdiv && req_src2[XLEN-1]) ? -req_src2 : req_src2;

  // Results must be visible in the MUL_LAT-th cycle after accept, so the
  // product is written one edge before MUL ends; with MUL_LAT==1 that edge is
  // the accept edge itself and the product comes straight from the request.
  assign w_ma         = (MUL_LAT == 1) ? req_src1 : r_a;
  assign w_mb         = (MUL_LAT == 1) ? req_src2 : r_b;
  assign w_mul_signed = (MUL_LAT == 1) ? (req_op == OP_MULT) : (r_op == OP_MULT);
  assign w_ext_a      = w_mul_signed ? {{XLEN{w_ma[XLEN-1]}}, w_ma} : {{XLEN{1'b0}}, w_ma};
  assign w_ext_b      = w_mul_signed ? {{XLEN{w_mb[XLEN-1]}}, w_mb} : {{XLEN{1'b0}}, w_mb};
  assign w_prod       = w_ext_a * w_ext_b;
  assign w_mul_fire   = !cancel &&
                        ((MUL_LAT == 1) ? (w_accept && w_req_mul)
                                        : (r_state == MUL && r_cnt == CW'(MUL_FIRE_CNT)));

  // Restoring step on magnitudes: the remainder always stays below the
  // divisor, so XLEN bits hold it and one extra bit catches the borrow.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_q_bit = !w_diff[XLEN];
  assign w_fix_q = r_neg_q ? -r_quo : r_quo;
  assign w_fix_r = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_req_mul)      w_next = MUL;
        else if (w_accept && w_req_div) w_next = DIV;
      end
      MUL:     if (r_cnt == CW'(MUL_LAT - 1)) w_next = IDLE;
      DIV:     if (r_cnt == CW'(XLEN - 1))    w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (cancel) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;

      if (w_accept) begin
        r_op    <= req_op;
        r_a     <= req_src1;
        r_b     <= req_src2;
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_abs_a;
        r_dvs   <= w_abs_b;
        r_neg_q <= w_req_sdiv && (req_src1[XLEN-1] ^ req_src2[XLEN-1]);
        r_neg_r <= w_req_sdiv && req_src1[XLEN-1];
        if (req_op == OP_MTHI) begin
          r_hi   <= req_src1;
          r_done <= 1'b1;
        end
        if (req_op == OP_MTLO) begin
          r_lo   <= req_src1;
          r_done <= 1'b1;
        end
      end else if (r_state == MUL) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == DIV) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_q_bit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], w_q_bit};
      end

      if (w_mul_fire) begin
        r_hi   <= w_prod[2*XLEN-1:XLEN];
        r_lo   <= w_prod[XLEN-1:0];
        r_done <= 1'b1;
      end

      if (r_state == FIX && !cancel) begin
        r_done <= 1'b1;
        if (r_b == '0) begin
          r_lo <= '1;
          r_hi <= r_a;
          r_dz <= 1'b1;
        end else begin
          r_lo <= w_fix_q;
          r_hi <= w_fix_r;
        end
      end
    end
  end

endmodule
